// File: rtl/mm_pkg.sv
// Shared matmul datapath constants, array FSM state, drain routing codes and helpers.
package mm_pkg;
  localparam int W        = 8;
  localparam int ACCW     = 24;
  localparam int T        = 2;
  localparam int ROWS_DEF = T;
  localparam int COLS_DEF = T;
  localparam bit SIGNED_M = 1'b0;
  localparam bit PIPE_MUL = 1'b0;

  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} array_state_e;
  typedef enum logic [1:0] {SRC_INJECT, SRC_WEST, SRC_EAST, SRC_NORTH} drain_src_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pe.sv
// Output-stationary MAC tile: forwards A east and B south, accumulates A*B,
// and presents its accumulator one cycle after drain_in while passing the drain token on.
module pe import mm_pkg::*; #(
  parameter int W        = mm_pkg::W,
  parameter int ACCW     = mm_pkg::ACCW,
  parameter bit SIGNED_M = mm_pkg::SIGNED_M,
  parameter bit PIPE_MUL = mm_pkg::PIPE_MUL
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    a_in,
  input  logic            a_valid_in,
  input  logic [W-1:0]    b_in,
  input  logic            b_valid_in,
  input  logic            acc_clear,
  input  logic            drain_in,
  output logic [W-1:0]    a_out,
  output logic            a_valid_out,
  output logic [W-1:0]    b_out,
  output logic            b_valid_out,
  output logic [ACCW-1:0] acc_out,
  output logic            acc_out_valid,
  output logic            drain_out
);
  localparam int PW = 2 * W;

  logic [PW-1:0]   w_prod;
  logic [ACCW-1:0] w_prod_ext;
  logic [ACCW-1:0] w_mac_val;
  logic            w_mac_en;
  logic [ACCW-1:0] r_acc;

  if (SIGNED_M) begin : g_signed
    assign w_prod     = PW'($signed(a_in)) * PW'($signed(b_in));
    assign w_prod_ext = ACCW'($signed(w_prod));
  end else begin : g_unsigned
    assign w_prod     = PW'(a_in) * PW'(b_in);
    assign w_prod_ext = ACCW'(w_prod);
  end

  if (PIPE_MUL) begin : g_pipe
    logic [ACCW-1:0] r_prod;
    logic            r_prod_vld;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prod     <= '0;
        r_prod_vld <= 1'b0;
      end else begin
        r_prod     <= w_prod_ext;
        r_prod_vld <= a_valid_in & b_valid_in;
      end
    end
    assign w_mac_val = r_prod;
    assign w_mac_en  = r_prod_vld;
  end else begin : g_comb
    assign w_mac_val = w_prod_ext;
    assign w_mac_en  = a_valid_in & b_valid_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out         <= '0;
      a_valid_out   <= 1'b0;
      b_out         <= '0;
      b_valid_out   <= 1'b0;
      acc_out       <= '0;
      acc_out_valid <= 1'b0;
      drain_out     <= 1'b0;
      r_acc         <= '0;
    end else begin
      a_out         <= a_in;
      a_valid_out   <= a_valid_in;
      b_out         <= b_in;
      b_valid_out   <= b_valid_in;
      drain_out     <= drain_in;
      acc_out_valid <= drain_in;
      if (drain_in) acc_out <= r_acc;
      if (acc_clear)     r_acc <= '0;
      else if (w_mac_en) r_acc <= r_acc + w_mac_val;
    end
  end
endmodule

// File: rtl/pe_drain_router.sv
// Static serpentine drain routing for tile (I,J): even rows run west->east,
// odd rows east->west, and each row start takes the token from the tile directly north.
module pe_drain_router import mm_pkg::*; #(
  parameter int I    = 0,
  parameter int J    = 0,
  parameter int ROWS = 1,
  parameter int COLS = 1
) (
  output drain_src_e o_src,
  output logic       o_is_tail
);
  localparam int TAIL_C = (ROWS % 2 == 0) ? 0 : COLS - 1;

  assign o_src = (I == 0 && J == 0) ? SRC_INJECT :
                 (I % 2 == 0) ? ((J > 0) ? SRC_WEST : SRC_NORTH) :
                                ((J < COLS - 1) ? SRC_EAST : SRC_NORTH);
  assign o_is_tail = (I == ROWS - 1) && (J == TAIL_C);
endmodule

// File: rtl/pe_array_stream.sv
// ROWSxCOLS systolic mesh with serpentine drain into a shadow bank that streams
// out one row per valid/ready transfer while the mesh is free to compute again.
module pe_array_stream import mm_pkg::*; #(
  parameter int W        = mm_pkg::W,
  parameter int ACCW     = mm_pkg::ACCW,
  parameter int ROWS     = mm_pkg::ROWS_DEF,
  parameter int COLS     = mm_pkg::COLS_DEF,
  parameter bit SIGNED_M = mm_pkg::SIGNED_M,
  parameter bit PIPE_MUL = mm_pkg::PIPE_MUL,
  localparam int RIW     = clog2_min1(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ROWS-1:0][W-1:0]     a_in_row,
  input  logic [ROWS-1:0]            a_in_valid,
  input  logic [COLS-1:0][W-1:0]     b_in_col,
  input  logic [COLS-1:0]            b_in_valid,
  input  logic                       acc_clear_block,
  input  logic                       drain_pulse,
  input  logic                       err_clear,
  output logic [COLS-1:0][ACCW-1:0]  out_data,
  output logic [RIW-1:0]             out_row_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       drain_overrun
);
  array_state_e    r_state;
  logic [RIW-1:0]  r_row;
  logic            r_overrun;
  logic [ACCW-1:0] r_shadow [ROWS][COLS];

  logic [W-1:0]    w_a_out   [ROWS][COLS];
  logic            w_a_vld   [ROWS][COLS];
  logic [W-1:0]    w_b_out   [ROWS][COLS];
  logic            w_b_vld   [ROWS][COLS];
  logic            w_drn_out [ROWS][COLS];
  logic            w_drn_in  [ROWS][COLS];
  logic [ACCW-1:0] w_acc     [ROWS][COLS];
  logic            w_acc_vld [ROWS][COLS];
  logic [ROWS*COLS-1:0] w_tail_hit;

  logic w_inject, w_tail_vld, w_emit, w_row_last;

  // Drain is only ever launched from IDLE; a pulse while busy is dropped.
  assign w_inject   = drain_pulse & (r_state == IDLE);
  assign w_tail_vld = |w_tail_hit;
  assign w_emit     = (r_state == EMIT);
  assign w_row_last = (r_row == RIW'(ROWS - 1));

  for (genvar i = 0; i < ROWS; i++) begin : g_r
    for (genvar j = 0; j < COLS; j++) begin : g_c
      localparam int JW = (j > 0) ? j - 1 : 0;
      localparam int JE = (j < COLS - 1) ? j + 1 : j;
      localparam int IN = (i > 0) ? i - 1 : 0;

      drain_src_e   w_src;
      logic         w_is_tail;
      logic [W-1:0] w_a_i, w_b_i;
      logic         w_av_i, w_bv_i;

      pe_drain_router #(.I(i), .J(j), .ROWS(ROWS), .COLS(COLS)) u_rt (
        .o_src     (w_src),
        .o_is_tail (w_is_tail)
      );

      assign w_a_i  = (j == 0) ? a_in_row[i]   : w_a_out[i][JW];
      assign w_av_i = (j == 0) ? a_in_valid[i] : w_a_vld[i][JW];
      assign w_b_i  = (i == 0) ? b_in_col[j]   : w_b_out[IN][j];
      assign w_bv_i = (i == 0) ? b_in_valid[j] : w_b_vld[IN][j];

      assign w_drn_in[i][j] = (w_src == SRC_INJECT) ? w_inject :
                              (w_src == SRC_WEST)   ? w_drn_out[i][JW] :
                              (w_src == SRC_EAST)   ? w_drn_out[i][JE] :
                                                      w_drn_out[IN][j];
      assign w_tail_hit[i*COLS + j] = w_is_tail & w_acc_vld[i][j];

      pe #(.W(W), .ACCW(ACCW), .SIGNED_M(SIGNED_M), .PIPE_MUL(PIPE_MUL)) u_pe (
        .clk           (clk),
        .rst_n         (rst_n),
        .a_in          (w_a_i),
        .a_valid_in    (w_av_i),
        .b_in          (w_b_i),
        .b_valid_in    (w_bv_i),
        .acc_clear     (acc_clear_block),
        .drain_in      (w_drn_in[i][j]),
        .a_out         (w_a_out[i][j]),
        .a_valid_out   (w_a_vld[i][j]),
        .b_out         (w_b_out[i][j]),
        .b_valid_out   (w_b_vld[i][j]),
        .acc_out       (w_acc[i][j]),
        .acc_out_valid (w_acc_vld[i][j]),
        .drain_out     (w_drn_out[i][j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          r_shadow[i][j] <= '0;
    end else begin
      if (drain_pulse && r_state != IDLE) r_overrun <= 1'b1;
      else if (err_clear)                 r_overrun <= 1'b0;
      case (r_state)
        IDLE: if (drain_pulse) r_state <= CAPTURE;
        CAPTURE: begin
          for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
              if (w_acc_vld[i][j]) r_shadow[i][j] <= w_acc[i][j];
          if (w_tail_vld) begin
            r_state <= EMIT;
            r_row   <= '0;
          end
        end
        EMIT: if (out_ready) begin
          if (w_row_last) begin
            r_state <= IDLE;
            r_row   <= '0;
          end else begin
            r_row <= r_row + RIW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign out_data[c] = w_emit ? r_shadow[r_row][c] : '0;
  end
  assign out_row_idx   = w_emit ? r_row : '0;
  assign out_valid     = w_emit;
  assign out_last      = w_emit & w_row_last;
  assign busy          = (r_state != IDLE);
  assign drain_overrun = r_overrun;
endmodule
